// File: rtl/sm_hex_display_mux.sv
// -----------------------------------------------------------------------------
// sm_hex_display_mux
//
// Time-multiplexed seven-segment driver for external LED digit modules.
// Scans DIGITS hex digits out of one packed number bus. Only one anode is
// driven at a time. Every digit slot begins with a blanked dead time, which
// prevents ghosting while the anode and segment lines switch over. Each digit
// has its own decimal point. Leading zero digits can be blanked. The number,
// dp and blank_lz inputs are copied into shadow registers once per frame, so
// input changes never tear a frame that is already being shown.
//
// Parameters
//   DIGITS          number of digits scanned (1..16)
//   REFRESH_DIV     clk cycles per digit slot (>= 2)
//   DEAD_CYCLES     blanked cycles at the start of each slot (0..REFRESH_DIV-1)
//   SEG_ACTIVE_LOW  1: segment/dot pins low = lit
//   AN_ACTIVE_LOW   1: anode pins low = digit selected
//
// Ports
//   clk             system clock
//   rst_n           asynchronous reset, active low
//   number          hex value; nibble i drives digit i (digit 0 is rightmost)
//   dp              per-digit decimal point, 1 = lit
//   blank_lz        1 = blank leading zero digits
//   enable          0 = display dark and scan frozen
//   seven_segments  {g,f,e,d,c,b,a}, polarity set by SEG_ACTIVE_LOW
//   dot             decimal point, polarity set by SEG_ACTIVE_LOW
//   anodes          one-hot digit select, polarity set by AN_ACTIVE_LOW
//   frame_start     registered 1-cycle pulse marking a shadow load
// -----------------------------------------------------------------------------
module sm_hex_display_mux #(
  parameter int DIGITS         = 8,
  parameter int REFRESH_DIV    = 50000,
  parameter int DEAD_CYCLES    = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   number,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  blank_lz,
  input  logic                  enable,
  output logic [6:0]            seven_segments,
  output logic                  dot,
  output logic [DIGITS-1:0]     anodes,
  output logic                  frame_start
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]  DEAD_END = CNT_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);

  // Pin-level "off" patterns. A lit/selected value is XORed with these
  // patterns, so a single rendering path serves both polarities.
  localparam logic [6:0]        SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic              DOT_OFF  = SEG_ACTIVE_LOW;
  localparam logic [DIGITS-1:0] AN_OFF   = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  // Scan state
  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;

  // Frame shadow registers
  logic [4*DIGITS-1:0] shadow_num;
  logic [DIGITS-1:0]   shadow_dp;
  logic                shadow_blz;

  // Rendering of the current slot
  logic                load;
  logic                in_dead;
  logic                show;
  logic [3:0]          sel_nib;
  logic                sel_dp;
  logic                sel_blank;
  logic [DIGITS-1:0]   an_onehot;
  logic [DIGITS-1:0]   blank_vec;
  logic                zero_above;

  // Hex to segments, bit order {g,f,e,d,c,b,a}, 1 = lit
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // A new frame begins on the first cycle of the digit-0 slot.
  assign load    = enable && (cnt == '0) && (idx == '0);
  assign in_dead = (cnt < DEAD_END);
  assign show    = enable && !in_dead;

  // ---------------------------------------------------------------------------
  // Prescaler and digit index
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (enable) begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        if (idx == IDX_LAST) begin
          idx <= '0;
        end else begin
          idx <= idx + 1'b1;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow load
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_num <= '0;
      shadow_dp  <= '0;
      shadow_blz <= 1'b0;
    end else if (load) begin
      shadow_num <= number;
      shadow_dp  <= dp;
      shadow_blz <= blank_lz;
    end
  end

  // ---------------------------------------------------------------------------
  // Leading-zero blanking. Walk from the most significant digit downward and
  // keep a running "everything above and including me is zero" flag. Digit 0
  // is excluded, so that a value of zero still shows a single '0'.
  // ---------------------------------------------------------------------------
  always_comb begin
    blank_vec  = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (shadow_num[i*4 +: 4] == 4'h0);
      if (i > 0) begin
        blank_vec[i] = shadow_blz && zero_above;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Current-digit select. This is a compare loop, not an array index, so that
  // DIGITS values that are not a power of two never read past the bus.
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_nib   = 4'h0;
    sel_dp    = 1'b0;
    sel_blank = 1'b0;
    an_onehot = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (IDX_W'(i) == idx) begin
        sel_nib      = shadow_num[i*4 +: 4];
        sel_dp       = shadow_dp[i];
        sel_blank    = blank_vec[i];
        an_onehot[i] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered pins. Every pin is a flop, and the async reset takes the
  // display dark at once. The one-hot anode vector comes from a single idx
  // value, so at most one anode is active in any cycle, even on the idx wrap.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seven_segments <= SEG_OFF;
      dot            <= DOT_OFF;
      anodes         <= AN_OFF;
      frame_start    <= 1'b0;
    end else begin
      frame_start <= load;
      if (show) begin
        // A blanked digit keeps its anode, so that its decimal point can still light.
        seven_segments <= (sel_blank ? 7'h00 : hex_to_seg(sel_nib)) ^ SEG_OFF;
        dot            <= sel_dp ^ DOT_OFF;
        anodes         <= an_onehot ^ AN_OFF;
      end else begin
        seven_segments <= SEG_OFF;
        dot            <= DOT_OFF;
        anodes         <= AN_OFF;
      end
    end
  end

endmodule

// File: tb/tb_sm_hex_display_mux.sv
// -----------------------------------------------------------------------------
// tb_sm_hex_display_mux
//
// Directed bench for a 4-digit, 8-cycle-slot, 2-cycle-dead-time, active-low
// instance. Variable cyc numbers the clock edges since reset release. The
// pins sampled 1 ns after edge c reflect the scan state just before that
// edge: cnt = c % 8 and idx = (c / 8) % 4.
// -----------------------------------------------------------------------------
module tb_sm_hex_display_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] number;
  logic [3:0]  dp;
  logic        blank_lz;
  logic        enable;
  logic [6:0]  seven_segments;
  logic        dot;
  logic [3:0]  anodes;
  logic        frame_start;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int an_viol  = 0;

  // Active-low segment patterns {g,f,e,d,c,b,a}
  localparam logic [6:0] S_0   = 7'h40;
  localparam logic [6:0] S_2   = 7'h24;
  localparam logic [6:0] S_1   = 7'h79;
  localparam logic [6:0] S_3   = 7'h30;
  localparam logic [6:0] S_4   = 7'h19;
  localparam logic [6:0] S_5   = 7'h12;
  localparam logic [6:0] S_6   = 7'h02;
  localparam logic [6:0] S_7   = 7'h78;
  localparam logic [6:0] S_8   = 7'h00;
  localparam logic [6:0] S_9   = 7'h10;
  localparam logic [6:0] S_C   = 7'h46;
  localparam logic [6:0] S_D   = 7'h21;
  localparam logic [6:0] S_OFF = 7'h7F;

  sm_hex_display_mux #(
    .DIGITS         (4),
    .REFRESH_DIV    (8),
    .DEAD_CYCLES    (2),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .number         (number),
    .dp             (dp),
    .blank_lz       (blank_lz),
    .enable         (enable),
    .seven_segments (seven_segments),
    .dot            (dot),
    .anodes         (anodes),
    .frame_start    (frame_start)
  );

  always #5 clk = ~clk;

  // Never more than one anode selected (active low -> zero bits)
  always @(negedge clk) begin
    if ($countones(~anodes) > 1) an_viol++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic check_dark(input string tag);
    check({tag, "_an"},  {28'h0, anodes}, 32'hF);
    check({tag, "_seg"}, {25'h0, seven_segments}, {25'h0, S_OFF});
    check({tag, "_dot"}, {31'h0, dot}, 32'h1);
    check({tag, "_fs"},  {31'h0, frame_start}, 32'h0);
  endtask

  task automatic check_digit(input string tag, input logic [3:0] an_exp,
                             input logic [6:0] seg_exp, input logic dot_exp);
    check({tag, "_an"},  {28'h0, anodes}, {28'h0, an_exp});
    check({tag, "_seg"}, {25'h0, seven_segments}, {25'h0, seg_exp});
    check({tag, "_dot"}, {31'h0, dot}, {31'h0, dot_exp});
  endtask

  initial begin
    rst_n    = 1'b0;
    enable   = 1'b1;
    number   = 16'h1234;
    dp       = 4'b0000;
    blank_lz = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_dark("reset");

    rst_n = 1'b1;
    cyc   = -1;

    // 1. Basic scan of 1234
    tick();
    check("fs_c0", {31'h0, frame_start}, 32'h1);
    check("an_c0", {28'h0, anodes}, 32'hF);
    tick();
    check("fs_c1", {31'h0, frame_start}, 32'h0);
    check("an_c1", {28'h0, anodes}, 32'hF);
    run_to(2);
    check_digit("d0_first", 4'b1110, S_4, 1'b1);
    run_to(7);
    check_digit("d0_last", 4'b1110, S_4, 1'b1);
    run_to(8);
    check("an_dead_d1", {28'h0, anodes}, 32'hF);
    run_to(10);
    check_digit("d1", 4'b1101, S_3, 1'b1);

    // 2. Mid-frame change stays invisible until the next frame
    run_to(12);
    number = 16'hABCD;
    run_to(18);
    check_digit("old_d2", 4'b1011, S_2, 1'b1);
    run_to(26);
    check_digit("old_d3", 4'b0111, S_1, 1'b1);
    run_to(31);
    check("fs_c31", {31'h0, frame_start}, 32'h0);
    run_to(32);
    check("fs_c32", {31'h0, frame_start}, 32'h1);
    check("an_c32", {28'h0, anodes}, 32'hF);
    run_to(34);
    check_digit("new_d0", 4'b1110, S_D, 1'b1);
    run_to(42);
    check_digit("new_d1", 4'b1101, S_C, 1'b1);

    // 3. Leading-zero blanking with a dot on a blanked digit
    number   = 16'h0050;
    blank_lz = 1'b1;
    dp       = 4'b0100;
    run_to(66);
    check_digit("lz_d0", 4'b1110, S_0, 1'b1);
    run_to(74);
    check_digit("lz_d1", 4'b1101, S_5, 1'b1);
    run_to(82);
    check_digit("lz_d2", 4'b1011, S_OFF, 1'b0);
    run_to(90);
    check_digit("lz_d3", 4'b0111, S_OFF, 1'b1);

    // 4. All-zero value: only digit 0 shows a '0'
    number = 16'h0000;
    dp     = 4'b0000;
    run_to(98);
    check_digit("z_d0", 4'b1110, S_0, 1'b1);
    run_to(106);
    check_digit("z_d1", 4'b1101, S_OFF, 1'b1);
    run_to(122);
    check_digit("z_d3", 4'b0111, S_OFF, 1'b1);

    // 5. Enable drop at cnt=5 of the digit-0 slot, then resume
    run_to(128);
    check("fs_c128", {31'h0, frame_start}, 32'h1);
    run_to(132);
    check("en_pre_an", {28'h0, anodes}, 32'hE);
    enable = 1'b0;
    tick();
    check_dark("en_off");
    run_to(137);
    check_dark("en_hold");
    enable = 1'b1;
    run_to(138);
    check("en_res_cnt5", {28'h0, anodes}, 32'hE);
    run_to(140);
    check("en_res_cnt7", {28'h0, anodes}, 32'hE);
    run_to(141);
    check("en_res_dead", {28'h0, anodes}, 32'hF);
    run_to(143);
    check("en_res_d1", {28'h0, anodes}, 32'hD);
    run_to(145);
    check("pre_rst_an", {28'h0, anodes}, 32'hD);

    // 6. Asynchronous reset mid-slot, then restart from digit 0
    number   = 16'h9876;
    blank_lz = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_dark("async_rst");
    tick();
    tick();
    check_dark("rst_hold");
    rst_n = 1'b1;
    cyc   = -1;
    tick();
    check("rst_fs_c0", {31'h0, frame_start}, 32'h1);
    check("rst_an_c0", {28'h0, anodes}, 32'hF);
    run_to(2);
    check_digit("rst_d0", 4'b1110, S_6, 1'b1);
    run_to(10);
    check_digit("rst_d1", 4'b1101, S_7, 1'b1);
    run_to(18);
    check_digit("rst_d2", 4'b1011, S_8, 1'b1);
    run_to(26);
    check_digit("rst_d3", 4'b0111, S_9, 1'b1);
    run_to(32);
    check("rst_fs_c32", {31'h0, frame_start}, 32'h1);

    check("an_onehot", an_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
